// File: rtl/alu8_issuer.sv
// Command sequencer driving a combinational 8-bit ALU: registers operands,
// captures the result after one settle cycle and returns it over a response handshake.
module alu8_issuer #(
    parameter logic [7:0] DIV0_VALUE = 8'hFF,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] OP_DIV = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       div0;
    logic [7:0] result;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment at the top keeps this block free of latches
    // when a case branch does not change state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, never the live inputs.
    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    assign result = div0 ? DIV0_VALUE : alu_out;

    // NOTE: every datapath register is cleared by reset so no X ever reaches
    // the ALU or the response channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            div0      <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                alu_a  <= cmd_use_acc ? acc : cmd_a;
                alu_b  <= cmd_b;
                alu_op <= cmd_op;
                div0   <= (cmd_op == OP_DIV) && (cmd_b == 8'h00);
            end
            if (state == EXEC) begin
                rsp_data  <= result;
                rsp_carry <= alu_carry;
                rsp_zero  <= (result == 8'h00);
                rsp_err   <= div0;
                // A substituted divide result must not pollute the chain.
                if (!div0) begin
                    acc <= result;
                end
                if (op_count != {CNT_W{1'b1}}) begin
                    op_count <= op_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu8_issuer.sv
// Directed bench for alu8_issuer with a behavioural model of the 16-op alu8bit
// hanging off the registered ALU ports.
module tb_alu8_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        cmd_use_acc;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_err;
    logic [7:0]  acc;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu8_issuer #(.DIV0_VALUE(8'hFF), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .acc         (acc),
        .op_count    (op_count)
    );

    // Combinational alu8bit: ADD SUB MUL DIV SHL SHR ROL ROR AND OR XOR NOR NAND XNOR GT EQ.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = alu_sum[8];
        alu_out   = 8'h00;
        case (alu_op)
            4'd0:  alu_out = alu_a + alu_b;
            4'd1:  alu_out = alu_a - alu_b;
            4'd2:  alu_out = alu_a * alu_b;
            4'd3:  alu_out = (alu_b != 8'h00) ? alu_a / alu_b : 8'h00;
            4'd4:  alu_out = alu_a << 1;
            4'd5:  alu_out = alu_a >> 1;
            4'd6:  alu_out = {alu_a[6:0], alu_a[7]};
            4'd7:  alu_out = {alu_a[0], alu_a[7:1]};
            4'd8:  alu_out = alu_a & alu_b;
            4'd9:  alu_out = alu_a | alu_b;
            4'd10: alu_out = alu_a ^ alu_b;
            4'd11: alu_out = ~(alu_a | alu_b);
            4'd12: alu_out = ~(alu_a & alu_b);
            4'd13: alu_out = ~(alu_a ^ alu_b);
            4'd14: alu_out = (alu_a > alu_b) ? 8'h01 : 8'h00;
            default: alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00;
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        use_acc;
        logic [7:0]  data;
        logic        carry;
        logic        zero;
        logic        err;
        logic [7:0]  acc_v;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bounded wait until the issuer is ready, sampled 1 time unit after an edge.
    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input vec_t v, input logic [7:0] acc_before);
        cmd_op      = v.op;
        cmd_a       = v.a;
        cmd_b       = v.b;
        cmd_use_acc = v.use_acc;
        cmd_valid   = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("alu_a",        32'(alu_a),     32'(v.use_acc ? acc_before : v.a));
        check("alu_b",        32'(alu_b),     32'(v.b));
        check("alu_op",       32'(alu_op),    32'(v.op));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid",    32'(rsp_valid), 32'd1);
        check("rsp_data",     32'(rsp_data),  32'(v.data));
        check("rsp_carry",    32'(rsp_carry), 32'(v.carry));
        check("rsp_zero",     32'(rsp_zero),  32'(v.zero));
        check("rsp_err",      32'(rsp_err),   32'(v.err));
        check("acc",          32'(acc),       32'(v.acc_v));
        check("op_count",     32'(op_count),  32'(v.cnt));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    logic [7:0] model_acc;

    initial begin
        //             op     a      b      acc  data   c     z     e     acc    cnt
        vecs[0] = '{4'd0,  8'hF4, 8'h0B, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 16'd1};
        vecs[1] = '{4'd15, 8'hF4, 8'h0B, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 16'd2};
        vecs[2] = '{4'd15, 8'h5A, 8'h5A, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 16'd3};
        vecs[3] = '{4'd0,  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 16'd4};
        vecs[4] = '{4'd0,  8'h99, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05, 16'd5};
        vecs[5] = '{4'd4,  8'h77, 8'h00, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h0A, 16'd6};
        vecs[6] = '{4'd3,  8'h20, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h0A, 16'd7};
        vecs[7] = '{4'd3,  8'h20, 8'h04, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 8'h08, 16'd8};
        vecs[8] = '{4'd1,  8'h00, 8'h09, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 16'd9};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_use_acc = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_acc",       32'(acc),       32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_alu",       32'({alu_a, alu_b, alu_op}), 32'd0);

        model_acc = 8'h00;
        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], model_acc);
            model_acc = vecs[i].acc_v;
        end

        // Backpressure: second command waits while the first response is held.
        cmd_op = 4'd0; cmd_a = 8'h01; cmd_b = 8'h02; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_op = 4'd10; cmd_a = 8'h0F; cmd_b = 8'hF0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data",  32'(rsp_data),  32'h03);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_alu_a",     32'(alu_a),     32'h01);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp2_alu_a",  32'(alu_a),  32'h0F);
        check("bp2_alu_b",  32'(alu_b),  32'hF0);
        check("bp2_alu_op", 32'(alu_op), 32'd10);
        @(posedge clk); #1;
        check("bp2_rsp_data", 32'(rsp_data), 32'hFF);
        check("bp2_acc",      32'(acc),      32'hFF);
        check("bp2_op_count", 32'(op_count), 32'd11);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during EXEC aborts the command entirely.
        cmd_op = 4'd0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_acc",       32'(acc),       32'd0);
        check("abort_op_count",  32'(op_count),  32'd0);
        check("abort_alu_op",    32'(alu_op),    32'd0);
        check("abort_rsp_data",  32'(rsp_data),  32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;
        run_cmd('{4'd0, 8'h55, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h07, 16'd1}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
